// File: rtl/prf_freelist.sv
// prf_freelist: circular free list of physical register indices.
// Rename pops up to ALLOC_WIDTH entries per cycle from the head.
// Commit pushes up to FREE_WIDTH reclaimed entries per cycle at the tail.
// Head checkpoints let a branch recovery restore the allocation state in one cycle.
// Optional macro FREELIST_CHECK_EN adds an in-list bitmap and a sticky free_err output.
// Pointers carry a wrap bit above the index. DEPTH must therefore be a power of two.
module prf_freelist #(
    parameter int PRF_NUM     = 64,
    parameter int ARF_NUM     = 32,
    parameter int ALLOC_WIDTH = 4,
    parameter int FREE_WIDTH  = 4,
    parameter int CP_SIZE     = 4,
    localparam int DEPTH      = PRF_NUM - ARF_NUM,
    localparam int PW         = $clog2(PRF_NUM),
    localparam int QW         = $clog2(DEPTH),
    localparam int CW         = $clog2(CP_SIZE)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pause,
    input  logic [ALLOC_WIDTH-1:0]      alloc_req,
    output logic [ALLOC_WIDTH*PW-1:0]   alloc_prf,
    output logic                        allocatable,
    input  logic [FREE_WIDTH-1:0]       free_valid,
    input  logic [FREE_WIDTH*PW-1:0]    free_prf,
    input  logic                        check,
    input  logic [CW-1:0]               check_idx,
    input  logic                        recover,
    input  logic [CW-1:0]               recover_idx,
    output logic [QW:0]                 free_count
`ifdef FREELIST_CHECK_EN
    ,
    output logic                        free_err
`endif
);

    logic [PW-1:0] r_entry [DEPTH];
    logic [QW:0]   r_head;
    logic [QW:0]   r_tail;
    logic [QW:0]   r_slot [CP_SIZE];

    logic [QW:0]   w_alloc_off [ALLOC_WIDTH];
    logic [QW:0]   w_alloc_cnt;
    logic [QW:0]   w_free_off [FREE_WIDTH];
    logic [QW:0]   w_free_cnt;
    logic [QW:0]   w_free_ptr [FREE_WIDTH];
    logic          w_alloc_fire;
    logic [QW:0]   w_head_next;
    logic [QW:0]   w_slot_rd;

    // Exclusive prefix popcounts pack sparse lanes onto consecutive entries.
    always_comb begin
        w_alloc_cnt = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_alloc_off[i] = w_alloc_cnt;
            w_alloc_cnt    = w_alloc_cnt + {{QW{1'b0}}, alloc_req[i]};
        end
        w_free_cnt = '0;
        for (int i = 0; i < FREE_WIDTH; i++) begin
            w_free_off[i] = w_free_cnt;
            w_free_cnt    = w_free_cnt + {{QW{1'b0}}, free_valid[i]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_lane
            logic [QW:0] w_rd_ptr;
            assign w_rd_ptr = r_head + w_alloc_off[gi];
            assign alloc_prf[gi*PW +: PW] = alloc_req[gi] ? r_entry[w_rd_ptr[QW-1:0]] : '0;
        end
        for (gi = 0; gi < FREE_WIDTH; gi++) begin : g_free_lane
            assign w_free_ptr[gi] = r_tail + w_free_off[gi];
        end
    endgenerate

    assign free_count   = r_tail - r_head;
    assign allocatable  = (free_count >= (QW+1)'(ALLOC_WIDTH));
    assign w_alloc_fire = allocatable & ~pause & ~recover & (|alloc_req);
    assign w_slot_rd    = r_slot[recover_idx];

    // Next head: recovery wins, otherwise advance by the number of served lanes.
    always_comb begin
        w_head_next = r_head;
        if (recover) begin
            w_head_next = w_slot_rd;
        end else if (w_alloc_fire) begin
            w_head_next = r_head + w_alloc_cnt;
        end
    end

    // Head and tail pointers. Reclaim always advances the tail.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= {1'b1, {QW{1'b0}}};
        end else begin
            r_head <= w_head_next;
            r_tail <= r_tail + w_free_cnt;
        end
    end

    // Entry storage: identity-offset fill at reset, reclaimed indices written at the tail.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= PW'(ARF_NUM + i);
            end
        end else begin
            for (int i = 0; i < FREE_WIDTH; i++) begin
                if (free_valid[i]) begin
                    r_entry[w_free_ptr[i][QW-1:0]] <= free_prf[i*PW +: PW];
                end
            end
        end
    end

    // Checkpoint slots capture the head after this cycle's allocations.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CP_SIZE; i++) begin
                r_slot[i] <= '0;
            end
        end else if (check && !recover) begin
            r_slot[check_idx] <= w_head_next;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [PRF_NUM-1:0] r_inlist;
    logic [PRF_NUM-1:0] w_inlist_next;
    logic [QW:0]        r_alloc_seen;
    logic [QW:0]        w_span;
    logic               r_free_err;
    logic               w_err_now;

    // Bitmap bookkeeping and error detection for the next state.
    always_comb begin
        w_inlist_next = r_inlist;
        w_err_now     = 1'b0;
        w_span        = r_head - w_slot_rd;
        if (recover) begin
            // Entries between the restored slot and the current head return to the list.
            for (int e = 0; e < DEPTH; e++) begin
                if ({1'b0, QW'(e) - w_slot_rd[QW-1:0]} < w_span) begin
                    w_inlist_next[r_entry[e]] = 1'b1;
                end
            end
        end else if (w_alloc_fire) begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                if (alloc_req[i]) begin
                    w_inlist_next[alloc_prf[i*PW +: PW]] = 1'b0;
                end
            end
        end
        for (int i = 0; i < FREE_WIDTH; i++) begin
            if (free_valid[i]) begin
                if (r_inlist[free_prf[i*PW +: PW]]) begin
                    w_err_now = 1'b1;
                end
                if ((r_alloc_seen < (QW+1)'(DEPTH)) && (free_prf[i*PW +: PW] < PW'(ARF_NUM))) begin
                    w_err_now = 1'b1;
                end
                w_inlist_next[free_prf[i*PW +: PW]] = 1'b1;
            end
        end
        if (free_count > (QW+1)'(DEPTH)) begin
            w_err_now = 1'b1;
        end
    end

    // Bitmap, saturating allocation counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < PRF_NUM; p++) begin
                r_inlist[p] <= (p >= ARF_NUM);
            end
            r_alloc_seen <= '0;
            r_free_err   <= 1'b0;
        end else begin
            r_inlist   <= w_inlist_next;
            r_free_err <= r_free_err | w_err_now;
            if (w_alloc_fire && (r_alloc_seen < (QW+1)'(DEPTH))) begin
                r_alloc_seen <= ((r_alloc_seen + w_alloc_cnt) > (QW+1)'(DEPTH)) ?
                                (QW+1)'(DEPTH) : (r_alloc_seen + w_alloc_cnt);
            end
        end
    end

    assign free_err = r_free_err;
`endif

endmodule

// File: tb/tb_prf_freelist.sv
// tb_prf_freelist: directed vector table, hand sequences and a randomized run
// against a history-based model of the free list.
module tb_prf_freelist;
    localparam int DEPTH = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        pause;
    logic [3:0]  alloc_req;
    logic [23:0] alloc_prf;
    logic        allocatable;
    logic [3:0]  free_valid;
    logic [23:0] free_prf;
    logic        check;
    logic [1:0]  check_idx;
    logic        recover;
    logic [1:0]  recover_idx;
    logic [5:0]  free_count;
`ifdef FREELIST_CHECK_EN
    logic        free_err;
`endif

    prf_freelist dut (
        .clock(clock),
        .reset(reset),
        .pause(pause),
        .alloc_req(alloc_req),
        .alloc_prf(alloc_prf),
        .allocatable(allocatable),
        .free_valid(free_valid),
        .free_prf(free_prf),
        .check(check),
        .check_idx(check_idx),
        .recover(recover),
        .recover_idx(recover_idx),
        .free_count(free_count)
`ifdef FREELIST_CHECK_EN
        ,
        .free_err(free_err)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        pause;
        logic [3:0]  req;
        logic [3:0]  fv;
        logic [23:0] fp;
        logic        chk;
        logic [1:0]  cidx;
        logic        rec;
        logic [1:0]  ridx;
        int          cnt;
        logic        ok;
        logic        chk_prf;
        logic [23:0] prf;
    } vec_t;

    vec_t tbl[18];

    typedef struct {
        int prf;
        int pos;
    } inf_t;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic vec_t mk(input logic p, input logic [3:0] req, input logic [3:0] fv,
                                input logic [23:0] fp, input logic chk, input logic [1:0] cidx,
                                input logic rec, input logic [1:0] ridx, input int cnt,
                                input logic ok, input logic cp, input logic [23:0] prf);
        vec_t v;
        v.pause = p; v.req = req; v.fv = fv; v.fp = fp; v.chk = chk; v.cidx = cidx;
        v.rec = rec; v.ridx = ridx; v.cnt = cnt; v.ok = ok; v.chk_prf = cp; v.prf = prf;
        return v;
    endfunction

    task automatic set_idle();
        pause = 0; alloc_req = 0; free_valid = 0; free_prf = 0;
        check = 0; check_idx = 0; recover = 0; recover_idx = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        set_idle();
        @(negedge clock);
        reset = 0;
    endtask

    task automatic run_table();
        for (int r = 0; r < 18; r++) begin
            pause = tbl[r].pause; alloc_req = tbl[r].req;
            free_valid = tbl[r].fv; free_prf = tbl[r].fp;
            check = tbl[r].chk; check_idx = tbl[r].cidx;
            recover = tbl[r].rec; recover_idx = tbl[r].ridx;
            #1;
            cmp($sformatf("tbl%0d_count", r), 32'(free_count), tbl[r].cnt);
            cmp($sformatf("tbl%0d_allocatable", r), 32'(allocatable), 32'(tbl[r].ok));
            if (tbl[r].chk_prf) begin
                for (int l = 0; l < 4; l++) begin
                    cmp($sformatf("tbl%0d_prf_lane%0d", r, l), 32'(alloc_prf[l*6 +: 6]),
                        32'(tbl[r].prf[l*6 +: 6]));
                end
            end
            $display("vec %0d req=%b fv=%b rec=%b count=%0d", r, alloc_req, free_valid, recover, free_count);
            @(negedge clock);
        end
        set_idle();
    endtask

    // Reset overrides every input, and checkpoint slots come back as zero.
    task automatic run_reset_seq();
        @(negedge clock);
        reset = 1; alloc_req = 4'hF; free_valid = 4'hF; free_prf = pk(1, 2, 3, 4);
        check = 1; check_idx = 3; recover = 1; recover_idx = 0;
        @(negedge clock);
        reset = 0;
        set_idle();
        #1;
        cmp("rst_count", 32'(free_count), 32);
        cmp("rst_allocatable", 32'(allocatable), 1);
        alloc_req = 4'hF;
        #1;
        for (int l = 0; l < 4; l++) begin
            cmp($sformatf("rst_prf_lane%0d", l), 32'(alloc_prf[l*6 +: 6]), 32 + l);
        end
        @(negedge clock);
        @(negedge clock);
        alloc_req = 0;
        #1;
        cmp("rst_after8_count", 32'(free_count), 24);
        recover = 1; recover_idx = 3; alloc_req = 4'hF;
        @(negedge clock);
        set_idle();
        #1;
        cmp("rst_slot_zero_count", 32'(free_count), 32);
        $display("seq reset: count=%0d", free_count);
    endtask

`ifdef FREELIST_CHECK_EN
    // Freeing an index already in the list raises a sticky error.
    task automatic run_err_seq();
        do_reset();
        #1;
        cmp("err_reset", 32'(free_err), 0);
        free_valid = 4'h1; free_prf = pk(40, 0, 0, 0);
        @(negedge clock);
        set_idle();
        #1;
        cmp("err_double_free", 32'(free_err), 1);
        repeat (3) @(negedge clock);
        #1;
        cmp("err_sticky", 32'(free_err), 1);
        do_reset();
        #1;
        cmp("err_cleared", 32'(free_err), 0);
        $display("seq free_err done");
    endtask
`endif

    // Random traffic against a model that keeps the full history of pushed indices.
    task automatic run_random();
        int   hist[$];
        int   mh;
        int   ck[4];
        bit   ckv[4];
        inf_t infl[$];
        inf_t t;
        int   last_freed;
        int   taken, cnt, k, s;
        logic [3:0] fv_raw, fv, req;
        logic [23:0] fp;
        logic p, chk, rec, okexp;
        logic [1:0] cidx, ridx;

        do_reset();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(32 + i);
        mh = 0;
        for (int i = 0; i < 4; i++) begin ck[i] = 0; ckv[i] = 1; end
        last_freed = -1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            p      = ($urandom_range(0, 7) == 0);
            req    = 4'($urandom);
            fv_raw = 4'($urandom);
            chk    = ($urandom_range(0, 3) == 0);
            cidx   = 2'($urandom);
            rec    = ($urandom_range(0, 7) == 0);
            ridx   = 2'($urandom);
            taken = 0; fv = 0; fp = 0;
            for (int l = 0; l < 4; l++) begin
                if (fv_raw[l] && taken < infl.size()) begin
                    fv[l] = 1;
                    fp[l*6 +: 6] = 6'(infl[taken].prf);
                    taken++;
                end
            end
            if (rec) begin
                s = ck[ridx];
                if (!ckv[ridx] || s > mh || last_freed >= s ||
                    (taken > 0 && infl[taken-1].pos >= s) ||
                    (hist.size() + taken - s > DEPTH)) begin
                    rec = 0;
                end
            end
            pause = p; alloc_req = req; free_valid = fv; free_prf = fp;
            check = chk; check_idx = cidx; recover = rec; recover_idx = ridx;
            #1;
            cnt   = hist.size() - mh;
            okexp = (cnt >= 4);
            cmp("rnd_count", 32'(free_count), cnt);
            cmp("rnd_allocatable", 32'(allocatable), 32'(okexp));
            if (okexp) begin
                k = 0;
                for (int l = 0; l < 4; l++) begin
                    if (req[l]) begin
                        cmp($sformatf("rnd_prf_lane%0d", l), 32'(alloc_prf[l*6 +: 6]), hist[mh + k]);
                        k++;
                    end else begin
                        cmp($sformatf("rnd_prf_lane%0d", l), 32'(alloc_prf[l*6 +: 6]), 0);
                    end
                end
            end
            $display("rnd %0d req=%b fv=%b chk=%b rec=%b count=%0d", cyc, req, fv, chk, rec, free_count);

            for (int l = 0; l < 4; l++) if (fv[l]) hist.push_back(int'(fp[l*6 +: 6]));
            if (taken > 0) last_freed = infl[taken-1].pos;
            for (int i = 0; i < taken; i++) void'(infl.pop_front());
            if (rec) begin
                s  = ck[ridx];
                mh = s;
                while (infl.size() > 0 && infl[$].pos >= s) void'(infl.pop_back());
                for (int j = 0; j < 4; j++) if (ck[j] > s) ckv[j] = 0;
            end else begin
                if (okexp && !p && req != 0) begin
                    for (int l = 0; l < 4; l++) begin
                        if (req[l]) begin
                            t.prf = hist[mh];
                            t.pos = mh;
                            infl.push_back(t);
                            mh++;
                        end
                    end
                end
                if (chk) begin
                    ck[cidx]  = mh;
                    ckv[cidx] = 1;
                end
            end
            @(negedge clock);
        end
        set_idle();
    endtask

    initial begin
        tbl[0]  = mk(1, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 32, 1, 1, pk(32, 33, 34, 35));
        tbl[1]  = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 32, 1, 1, pk(32, 33, 34, 35));
        tbl[2]  = mk(0, 4'hA, 4'h0, 24'h0,            0, 0, 0, 0, 28, 1, 1, pk(0, 36, 0, 37));
        tbl[3]  = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 26, 1, 1, pk(38, 39, 40, 41));
        tbl[4]  = mk(0, 4'h3, 4'h0, 24'h0,            1, 2, 0, 0, 22, 1, 1, pk(42, 43, 0, 0));
        tbl[5]  = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 20, 1, 1, pk(44, 45, 46, 47));
        tbl[6]  = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 16, 1, 1, pk(48, 49, 50, 51));
        tbl[7]  = mk(0, 4'hF, 4'h1, pk(7, 0, 0, 0),   0, 0, 1, 2, 12, 1, 1, pk(52, 53, 54, 55));
        tbl[8]  = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 21, 1, 1, pk(44, 45, 46, 47));
        tbl[9]  = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 17, 1, 1, pk(48, 49, 50, 51));
        tbl[10] = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0, 13, 1, 1, pk(52, 53, 54, 55));
        tbl[11] = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0,  9, 1, 1, pk(56, 57, 58, 59));
        tbl[12] = mk(0, 4'h3, 4'h0, 24'h0,            0, 0, 0, 0,  5, 1, 1, pk(60, 61, 0, 0));
        tbl[13] = mk(0, 4'h1, 4'h0, 24'h0,            0, 0, 0, 0,  3, 0, 0, 24'h0);
        tbl[14] = mk(0, 4'h0, 4'hF, pk(10, 11, 12, 13), 0, 0, 0, 0, 3, 0, 0, 24'h0);
        tbl[15] = mk(0, 4'hF, 4'h3, pk(5, 9, 0, 0),   0, 0, 0, 0,  7, 1, 1, pk(62, 63, 7, 10));
        tbl[16] = mk(0, 4'hF, 4'h0, 24'h0,            0, 0, 0, 0,  5, 1, 1, pk(11, 12, 13, 5));
        tbl[17] = mk(0, 4'h0, 4'h0, 24'h0,            0, 0, 0, 0,  1, 0, 0, 24'h0);

        reset = 1;
        set_idle();
        do_reset();
        run_table();
        run_reset_seq();
`ifdef FREELIST_CHECK_EN
        run_err_seq();
`endif
        run_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prf_freelist.md
Name: prf_freelist

Overview:
- Supplies free physical register indices to the rename stage and reclaims them from commit.
- Each cycle the rename stage pops up to ALLOC_WIDTH PRF indices, and commit pushes up to FREE_WIDTH stale PRF indices (prev_rd of retired uops).
- Implemented as a circular FIFO with head checkpoints, so a branch recovery restores the allocation state in one cycle.

Parameters:
- PRF_NUM, 64, number of physical registers
- ARF_NUM, 32, number of architectural registers, identity-mapped at reset
- ALLOC_WIDTH, 4, rename lanes (equals RENAME_WIDTH)
- FREE_WIDTH, 4, commit lanes
- CP_SIZE, 4, checkpoint slots (equals RAT_CP_SIZE)
- Derived:
  - DEPTH = PRF_NUM-ARF_NUM
  - PW = $clog2(PRF_NUM)
  - QW = $clog2(DEPTH)
  - CW = $clog2(CP_SIZE)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- pause  in  1  rename stalled; no allocation this cycle
- alloc_req  in  ALLOC_WIDTH  per-lane request for a destination PRF
- alloc_prf  out  ALLOC_WIDTH*PW  PRF index per lane, lane i at bits [i*PW +: PW]
- allocatable  out  1  count >= ALLOC_WIDTH
- free_valid  in  FREE_WIDTH  per-lane reclaim valid
- free_prf  in  FREE_WIDTH*PW  PRF index to reclaim per lane
- check  in  1  take checkpoint this cycle
- check_idx  in  CW  checkpoint slot written
- recover  in  1  restore allocation state
- recover_idx  in  CW  checkpoint slot read
- free_count  out  QW+1  number of free entries currently held

Behaviour:
- Storage: DEPTH entries of PW bits; head/tail pointers QW+1 bits wide (MSB is the wrap bit); free_count = tail - head.
- Reset (one cycle, overrides all other inputs):
  - entry[i] = ARF_NUM+i
  - head = 0, tail = {1'b1, QW'b0}
  - free_count = DEPTH, allocatable = 1
  - all checkpoint slots = 0
- Allocation, combinational outputs:
  - Let k(i) = popcount(alloc_req[i-1:0]).
  - alloc_prf[i] = entry[(head+k(i)) mod DEPTH] when alloc_req[i]; otherwise 0.
  - Requests are packed: sparse lanes consume consecutive entries.
- Allocation fires when allocatable & ~pause & ~recover & |alloc_req; then head_next = head + popcount(alloc_req).
- All-or-nothing: when allocatable=0 no lane is served; head is unchanged and alloc_prf is don't-care.
- Reclaim:
  - Each free_valid lane writes free_prf into entry[(tail+j(i)) mod DEPTH], with j(i) = popcount(free_valid[i-1:0]).
  - tail_next = tail + popcount(free_valid).
  - Reclaim is never blocked, including during pause and recover.
  - Entries freed this cycle are not allocatable until the next cycle; there is no bypass.
- Checkpoint: when check & ~recover, slot[check_idx] <= head_next, i.e. including this cycle's allocations.
- Recover: head <= slot[recover_idx]; this cycle's alloc_req and check are ignored, and tail still advances for this cycle's frees.
- Overflow is impossible by construction: conservation of PRFs keeps (tail - any live checkpoint) <= DEPTH.
- Wrap-around: indices are taken mod DEPTH; the wrap bit distinguishes full (free_count=DEPTH) from empty (free_count=0).
- Latency: alloc_prf is zero-cycle; pointer and checkpoint updates are visible the next cycle.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- When defined:
  - Adds a PRF_NUM-bit in-list bitmap; reset sets bits ARF_NUM..PRF_NUM-1.
  - An allocation clears the allocated bit; a free sets it.
  - Recover re-derives the bitmap by setting bits for entries in [slot, head).
  - Adds output port free_err (1 bit, sticky, reset 0). It is set on:
    - a free of a PRF whose bit is already set (double free);
    - a free of an index below ARF_NUM during the first DEPTH allocations;
    - free_count exceeding DEPTH.
- When undefined: no bitmap, no free_err port, identical functional behaviour otherwise.

Test Plan:
- After reset, alloc_req=4'b1111, pause=0 -> alloc_prf = 32,33,34,35; next cycle free_count 32->28.
- Sparse request alloc_req=4'b1010 with head=4 -> lane1 = 36, lane3 = 37, lanes 0 and 2 = 0; head -> 6.
- Drain to free_count=3, alloc_req=4'b0001 -> allocatable=0; head unchanged; alloc_prf is don't-care.
- Same cycle: alloc 4 and free_valid=4'b0011 with PRFs 5,9 -> free_count changes by -2; entries 5,9 are written at tail, tail wrapping to index 0 when at DEPTH-1.
- check (slot 2) with a 2-lane alloc at head=10 -> slot2=12. Alloc 8 more, then recover idx 2 with a simultaneous 1 free -> head=12, free_count = previous +8 +1, alloc ignored that cycle.
- With FREELIST_CHECK_EN: free PRF 40 while 40 is still in the list -> free_err=1 next cycle and it stays 1 until reset.
